// File: rtl/sdram_frame_pkg.sv
// Shared types and helpers for the SDRAM triple-buffer frame scheduler.
// Holds the buffer index and address types, the FSM encoding and the buffer base-address helper.
package sdram_frame_pkg;

    localparam int IDX_W  = 2;
    localparam int ADDR_W = 24;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic addr_t base_addr(input idx_t idx, input addr_t stride);
        return addr_t'(idx) * stride;
    endfunction

endpackage

// File: rtl/sdram_frame_sched_load_pulse_gen.sv
// Retriggerable load pulse: high for load_cycles clocks after each trigger.
// A trigger during an active pulse restarts the count, so the pulse stretches without a gap.
module load_pulse_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [7:0] load_cycles,
    output logic       pulse
);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else if (trig) begin
            cnt_reg <= load_cycles;
        end else if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    assign pulse = (cnt_reg != 8'd0);

endmodule

// File: rtl/sdram_frame_sched.sv
// Triple-buffer frame scheduler: rotates write/read/pending buffer indices so the
// writer never touches the displayed frame and the LCD always picks up the newest finished frame.
module sdram_frame_sched
    import sdram_frame_pkg::*;
#(
    parameter logic [23:0] FRAME_SIZE  = 24'd384000,
    parameter logic [23:0] BUF_STRIDE  = 24'h080000,
    parameter int          LOAD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic        wr_frame_done,
    input  logic        rd_frame_start,
    output logic [23:0] wr_min_addr,
    output logic [23:0] wr_max_addr,
    output logic        wr_load,
    output logic [23:0] rd_min_addr,
    output logic [23:0] rd_max_addr,
    output logic        rd_load,
    output logic        rd_frame_valid,
    output logic [15:0] drop_cnt
);

    state_t      state_reg, state_next;
    idx_t        w_reg, w_next, r_reg, r_next, p_reg, p_next;
    logic        pv_reg, pv_next;
    logic        rfv_reg, rfv_next;
    logic [15:0] drop_reg, drop_next;
    addr_t       wr_min_reg, wr_max_reg, rd_min_reg, rd_max_reg;
    logic        wr_swap, rd_swap;
    logic        wr_pulse, rd_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            w_reg      <= idx_t'(0);
            r_reg      <= idx_t'(1);
            p_reg      <= idx_t'(2);
            pv_reg     <= 1'b0;
            rfv_reg    <= 1'b0;
            drop_reg   <= 16'd0;
            wr_min_reg <= base_addr(idx_t'(0), BUF_STRIDE);
            wr_max_reg <= base_addr(idx_t'(0), BUF_STRIDE) + FRAME_SIZE;
            rd_min_reg <= base_addr(idx_t'(1), BUF_STRIDE);
            rd_max_reg <= base_addr(idx_t'(1), BUF_STRIDE) + FRAME_SIZE;
        end else begin
            state_reg  <= state_next;
            w_reg      <= w_next;
            r_reg      <= r_next;
            p_reg      <= p_next;
            pv_reg     <= pv_next;
            rfv_reg    <= rfv_next;
            drop_reg   <= drop_next;
            wr_min_reg <= base_addr(w_next, BUF_STRIDE);
            wr_max_reg <= base_addr(w_next, BUF_STRIDE) + FRAME_SIZE;
            rd_min_reg <= base_addr(r_next, BUF_STRIDE);
            rd_max_reg <= base_addr(r_next, BUF_STRIDE) + FRAME_SIZE;
        end
    end

    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        r_next     = r_reg;
        p_next     = p_reg;
        pv_next    = pv_reg;
        rfv_next   = rfv_reg;
        drop_next  = drop_reg;
        wr_swap    = 1'b0;
        rd_swap    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sdram_init_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_frame_done) begin
                    wr_swap = 1'b1;
                    w_next  = p_reg;
                    p_next  = w_reg;
                    pv_next = 1'b1;
                    if (pv_reg && drop_reg != 16'hFFFF) begin
                        drop_next = drop_reg + 16'd1;
                    end
                end
                // Read swap sees the pending buffer as left by a same-cycle write swap.
                if (rd_frame_start && pv_next) begin
                    rd_swap  = 1'b1;
                    r_next   = p_next;
                    p_next   = r_reg;
                    pv_next  = 1'b0;
                    rfv_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    load_pulse_gen u_wr_load (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (wr_swap),
        .load_cycles (8'(LOAD_CYCLES)),
        .pulse       (wr_pulse)
    );

    load_pulse_gen u_rd_load (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (rd_swap),
        .load_cycles (8'(LOAD_CYCLES)),
        .pulse       (rd_pulse)
    );

    assign wr_load        = (state_reg == ST_IDLE) | wr_pulse;
    assign rd_load        = (state_reg == ST_IDLE) | rd_pulse;
    assign wr_min_addr    = wr_min_reg;
    assign wr_max_addr    = wr_max_reg;
    assign rd_min_addr    = rd_min_reg;
    assign rd_max_addr    = rd_max_reg;
    assign rd_frame_valid = rfv_reg;
    assign drop_cnt       = drop_reg;

endmodule

// File: doc/sdram_frame_sched.md
Name: sdram_frame_sched

Overview:
- Triple-buffer frame scheduler for the SDRAM frame store between the UDP image receiver (write port) and the RGB LCD driver (read port).
- Owns the write/read address windows and the load pulses of the SDRAM FIFO controller.
- Guarantees the writer never overwrites the frame being displayed, and that the LCD always switches to the newest complete frame at a frame boundary.
- Runs in the SDRAM controller reference clock domain. Inputs arrive already synchronised as single-cycle pulses.

Parameters:
- FRAME_SIZE, 24'd384000, 16-bit words per frame (800*480).
- BUF_STRIDE, 24'h080000, address distance between frame buffers. Must be >= FRAME_SIZE, and 3*BUF_STRIDE <= 2^24.
- LOAD_CYCLES, 8, width in clocks of each wr_load/rd_load pulse. Range 1..255.

Ports:
- clk, input, 1, SDRAM controller reference clock (100 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- sdram_init_done, input, 1, SDRAM initialisation complete (level).
- wr_frame_done, input, 1, one-cycle pulse: writer has finished a full frame.
- rd_frame_start, input, 1, one-cycle pulse: LCD is at vertical blanking and may switch buffer.
- wr_min_addr, output, 24, write window start.
- wr_max_addr, output, 24, write window end.
- wr_load, output, 1, write port reset (clears write FIFO and reloads address).
- rd_min_addr, output, 24, read window start.
- rd_max_addr, output, 24, read window end.
- rd_load, output, 1, read port reset.
- rd_frame_valid, output, 1, read buffer holds a completed frame.
- drop_cnt, output, 16, frames overwritten before being displayed (saturating).

Behaviour:
- Indices w (write), r (read), p (pending) are 2-bit registers. They are always a permutation of {0,1,2}. p_vld flags p as a completed, unshown frame.
- Reset values:
  - w=0, r=1, p=2, p_vld=0, rd_frame_valid=0, drop_cnt=0.
  - wr_min=0, wr_max=FRAME_SIZE, rd_min=BUF_STRIDE, rd_max=BUF_STRIDE+FRAME_SIZE.
  - wr_load=1, rd_load=1; state=IDLE.
- FSM states:
  - IDLE: loads held at 1, all input pulses ignored. Moves to RUN on the first cycle sdram_init_done=1; both loads drop to 0 the next cycle.
  - RUN: normal operation. sdram_init_done is not re-checked.
- Write swap (RUN, wr_frame_done=1): swap w and p, set p_vld=1. If p_vld was already 1, drop_cnt increments (saturating at 16'hFFFF).
- Read swap (RUN, rd_frame_start=1 and p_vld after any same-cycle write swap): swap r and p, clear p_vld, set rd_frame_valid=1 (sticky until reset).
- rd_frame_start with no pending frame: no change, no rd_load.
- Simultaneous pulses: apply the write swap first, then the read swap, in the same cycle. Result: w'=p, r'=w, p'=r, p_vld'=0. Both loads fire. The just-finished frame is displayed and not counted as dropped.
- Addresses: min = idx*BUF_STRIDE, max = min+FRAME_SIZE. Registered, updated the cycle after the triggering pulse.
- Load pulses:
  - A swap at cycle t gives the new address at t+1, and the matching load is high for cycles t+1..t+LOAD_CYCLES.
  - Each port has its own 8-bit down-counter. A swap during an active pulse reloads the counter, so the pulse is extended. There is never a gap.
- Asynchronous reset mid-operation returns all outputs immediately to their reset values, including both loads=1.

Decomposition:
- Shared package sdram_frame_pkg:
  - buffer index width (2) and the 24-bit address width.
  - FSM state encoding ST_IDLE/ST_RUN.
  - helper function base_addr(idx).
- One natural sub-module: load_pulse_gen. It takes a trigger and LOAD_CYCLES and produces a retriggerable pulse. It is instantiated twice, for wr_load and rd_load.

Test Plan:
- Reset, then sdram_init_done high at cycle 10:
  - loads stay 1 through cycle 10 and are 0 from cycle 11.
  - wr_min=0, rd_min=0x080000, rd_frame_valid=0.
- wr_frame_done, then rd_frame_start 100 cycles later:
  - after the write: w=2, wr_min=0x100000, wr_load high 8 cycles.
  - after the read: r=0, rd_min=0, rd_max=384000, rd_load high 8 cycles, rd_frame_valid=1.
- Three wr_frame_done pulses, no rd_frame_start:
  - drop_cnt=2; w alternates 2,0,2; r stays 1; rd_load never asserts.
- wr_frame_done and rd_frame_start in the same cycle, from reset state:
  - w=2, r=0, p=1, p_vld=0; both loads pulse; drop_cnt unchanged.
- wr_frame_done, then a second one 3 cycles later:
  - wr_load is high continuously for 3+8 cycles.
  - wr_min goes 0x100000, then 0x000000.
- Pulses before sdram_init_done are ignored. Reset asserted mid-pulse returns all outputs to reset values with no clock edge.
